loop_sequencer: RTL

LOOP_SEQUENCER -- requirements
Module: loop_sequencer

---
 rtl/cdu_pkg.sv | 22 ++
 rtl/read_counter.sv | 39 +++
 rtl/loop_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cdu_pkg.sv
// rtl/cdu_pkg.sv - shared loop-state enum, defaults and read-counter step helper
package cdu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COARSE = 2'd1,
        ST_FINE1  = 2'd2,
        ST_FINE2  = 2'd3
    } loop_state_e;

    localparam int SETTLE_N_DEF = 8;
    localparam int RDCNT_W      = 16;
    localparam int SETTLE_W     = 8;

    // Coarse tracking moves the read pointer in large strides, fine stages by one.
    function automatic logic [RDCNT_W-1:0] step_size(input loop_state_e st, input int shift);
        logic [RDCNT_W-1:0] unit;
        unit = RDCNT_W'(1);
        return (st == ST_COARSE) ? (unit << shift) : unit;
    endfunction

endpackage

// File: rtl/read_counter.sv
// rtl/read_counter.sv - wrapping up/down read counter with registered step pulses
module read_counter
    import cdu_pkg::*;
#(
    parameter int W = RDCNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic [W-1:0] step,
    output logic [W-1:0] count,
    output logic         step_up,
    output logic         step_dn
);

    logic do_up;
    logic do_dn;

    assign do_up = inc && !dec;
    assign do_dn = dec && !inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            step_up <= 1'b0;
            step_dn <= 1'b0;
        end else begin
            step_up <= do_up;
            step_dn <= do_dn;
            if (do_up) begin
                count <= count + step;
            end else if (do_dn) begin
                count <= count - step;
            end
        end
    end

endmodule

// File: rtl/loop_sequencer.sv
// rtl/loop_sequencer.sv - coarse/fine tracking loop sequencer; LOOP_FINE2_EN adds the FINE2 stage
module loop_sequencer
    import cdu_pkg::*;
#(
    parameter int SETTLE_N     = SETTLE_N_DEF,
    parameter int COARSE_SHIFT = 4
) (
    input  logic               CLOCKH,
    input  logic               rst_n,
    input  logic               FAZ2HI,
    input  logic               fine1_en,
    input  logic               ATPC1,
    input  logic               ATPF1,
    input  logic               ATPF2,
    input  logic               AUPLVL,
    input  logic               ADNLVL,
    output logic               ATLC1H,
    output logic               ATLF1H,
    output logic               ATLF2H,
    output logic               AAO,
    output logic               STEP_UP,
    output logic               STEP_DN,
    output logic [RDCNT_W-1:0] RDCNT
);

    localparam logic [SETTLE_W-1:0] SETTLE_LIM  = SETTLE_W'(SETTLE_N);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_LIM - 1'b1;

`ifdef LOOP_FINE2_EN
    localparam loop_state_e TERM_ST = ST_FINE2;
`else
    localparam loop_state_e TERM_ST = ST_FINE1;
`endif

    loop_state_e         state_q;
    loop_state_e         state_d;
    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;
    logic                aao_q;
    logic                aao_d;
    logic                fallback;
    logic                quiet;
    logic                step_inc;
    logic                step_dec;
    logic [RDCNT_W-1:0]  step_amt;

    assign fallback = ATPC1 || !fine1_en;

    always_comb begin
        quiet = 1'b1;
        case (state_q)
            ST_FINE1: quiet = !ATPF1;
            ST_FINE2: quiet = !ATPF2;
            default:  quiet = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        aao_d   = aao_q;
        if (FAZ2HI) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_COARSE;
                    cnt_d   = '0;
                end
                default: begin
                    if (fallback) begin
                        state_d = ST_COARSE;
                        cnt_d   = '0;
                    end else if (state_q == ST_FINE2 && ATPF1) begin
                        state_d = ST_FINE1;
                        cnt_d   = '0;
                    end else if (!quiet) begin
                        cnt_d = '0;
                    end else if (cnt_q >= SETTLE_LAST) begin
                        // The terminal stage holds a saturated count so AAO stays up.
                        if (state_q == TERM_ST) begin
                            cnt_d = SETTLE_LIM;
                        end else begin
                            state_d = (state_q == ST_COARSE) ? ST_FINE1 : ST_FINE2;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
            aao_d = (state_d == TERM_ST) && (cnt_d == SETTLE_LIM);
        end
    end

    always_ff @(posedge CLOCKH or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            aao_q   <= 1'b0;
            ATLC1H  <= 1'b0;
            ATLF1H  <= 1'b0;
            ATLF2H  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            aao_q   <= aao_d;
            ATLC1H  <= (state_d == ST_COARSE);
            ATLF1H  <= (state_d == ST_FINE1);
`ifdef LOOP_FINE2_EN
            ATLF2H  <= (state_d == ST_FINE2);
`else
            ATLF2H  <= 1'b0;
`endif
        end
    end

    assign AAO = aao_q;

    // Step size follows the stage the strobe arrived in, not the one it moves to.
    assign step_inc = FAZ2HI && (state_q != ST_IDLE) && AUPLVL && !ADNLVL;
    assign step_dec = FAZ2HI && (state_q != ST_IDLE) && ADNLVL && !AUPLVL;
    assign step_amt = step_size(state_q, COARSE_SHIFT);

    read_counter #(
        .W (RDCNT_W)
    ) u_read_counter (
        .clk     (CLOCKH),
        .rst_n   (rst_n),
        .inc     (step_inc),
        .dec     (step_dec),
        .step    (step_amt),
        .count   (RDCNT),
        .step_up (STEP_UP),
        .step_dn (STEP_DN)
    );

endmodule
